axis_framer: RTL and testbench
==============================

AXIS_FRAMER -- requirements
Module: axis_framer

Interface
REQ-001 SHALL have parameter DW, default 8: data width in bits for the stream and for len.
REQ-002 SHALL have parameter CW, default 16: width of pkt_cnt, present only with the stats feature.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 s_tdata  input  DW  upstream raw byte stream, carrying no framing.
REQ-006 s_tvalid  input  1  upstream data valid.
REQ-007 s_tready  output  1  block can accept an upstream beat.
REQ-008 m_tdata  output  DW  framed data to the packet_add stage.
REQ-009 m_tvalid  output  1  output beat valid.
REQ-010 m_tlast  output  1  marks the last beat of a packet.
REQ-011 m_tready  input  1  downstream ready.
REQ-012 len  input  DW  packet length in beats; 0 means 2^DW.
REQ-013 pkt_cnt  output  CW  count of completed packets; present only with AXIS_FRAMER_STATS_EN.

Function
REQ-014 An upstream beat SHALL transfer when s_tvalid && s_tready; an output beat SHALL transfer when m_tvalid && m_tready.
REQ-015 Datapath SHALL be a 2-entry skid buffer with registered outputs: main register plus skid register.
  - Latency from an accepted upstream beat to m_tvalid SHALL be 1 cycle when the main register is empty.
REQ-016 s_tready SHALL be a registered signal, equal to 1 exactly when the skid register is empty.
REQ-017 Throughput SHALL be 1 beat/cycle while m_tready=1.
  - No beat SHALL be dropped, duplicated or reordered under any pattern of m_tready.
REQ-018 When m_tvalid=1 and m_tready=0, m_tdata, m_tvalid and m_tlast SHALL hold stable.
REQ-019 The FSM SHALL have two states, IDLE and BODY, plus a beat counter bcnt of width DW+1.
  - IDLE: no packet in progress; bcnt=0.
  - IDLE -> BODY: on the upstream beat that starts a packet; len is latched into len_q, with 0 mapped to 2^DW.
  - BODY: bcnt increments on each accepted upstream beat.
  - The beat for which bcnt == len_q-1 SHALL be tagged tlast; the FSM then returns to IDLE with bcnt=0.
  - len_q = 1: every beat SHALL be tagged tlast, and the FSM stays in IDLE.
REQ-020 The tlast tag SHALL be computed at upstream acceptance and stored with the beat in the skid/main registers.
REQ-021 Changes to len while in BODY SHALL be ignored until the next IDLE -> BODY transition.
REQ-022 A stall on s_tvalid mid-packet SHALL NOT abort or truncate the packet; counting resumes on the next beat.
REQ-023 Simultaneous events (upstream accept and output transfer in the same cycle) SHALL both take effect without a bubble.

Reset
REQ-024 While rst=0, the block SHALL asynchronously force: m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, state=IDLE, bcnt=0, len_q=0, pkt_cnt=0, both buffer entries empty.
REQ-025 On the first rising clk edge after rst deasserts, s_tready SHALL become 1.
REQ-026 Reset asserted mid-packet SHALL discard all buffered beats and the partial count.
  - The first beat after reset SHALL start a new packet using the current len.

Configuration
REQ-027 Macro AXIS_FRAMER_STATS_EN, when defined, SHALL add the pkt_cnt output.
  - pkt_cnt increments by 1 on each output transfer with m_tlast=1.
  - pkt_cnt wraps modulo 2^CW.
REQ-028 Without AXIS_FRAMER_STATS_EN, the port pkt_cnt and its register SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-029 len=4, 12 consecutive bytes 1..12, m_tready=1 -> m_tlast on bytes 4, 8 and 12; first m_tvalid 1 cycle after first accept; pkt_cnt=3.
REQ-030 len=64, 256 beats with m_tready toggling 1,0,1,0 -> output sequence equals input; tlast every 64th beat; s_tready never 0 for more than 1 cycle per stall.
REQ-031 len=0, 512 beats -> tlast only on beats 256 and 512.
REQ-032 len=1 -> every beat has m_tlast=1; len changed 8 -> 3 after beat 2 of a packet -> tlast on beat 8, then every 3 beats.
REQ-033 m_tready=0 for 5 cycles with upstream streaming -> exactly 2 beats buffered, s_tready=0; on release, beats drain in order with 0 loss.
REQ-034 rst=0 asserted after beat 3 of a len=8 packet -> outputs zero immediately; after release, the next 8 beats form one packet with tlast on the 8th.

Source files
------------

// File: rtl/axis_framer.sv
// AXI-stream framer: 2-entry skid buffer that tags m_tlast every len beats.
// Optional packet counter output pkt_cnt enabled by `define AXIS_FRAMER_STATS_EN.
module axis_framer #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  input  logic [DW-1:0] len
`ifdef AXIS_FRAMER_STATS_EN
  ,
  output logic [CW-1:0] pkt_cnt
`endif
);

  typedef enum logic {
    IDLE,
    BODY
  } state_t;

  state_t        state_q;
  logic [DW:0]   bcnt_q;
  logic [DW:0]   len_q;

  logic          main_vld_q, main_vld_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic          main_last_q, main_last_d;
  logic          sk_vld_q, sk_vld_d;
  logic [DW-1:0] sk_data_q, sk_data_d;
  logic          sk_last_q, sk_last_d;
  logic          rdy_q, rdy_d;

  logic          acc;
  logic          oxfer;
  logic [DW:0]   len_eff;
  logic [DW:0]   cur_len;
  logic          tag_last;

  assign acc   = s_tvalid && rdy_q;
  assign oxfer = main_vld_q && m_tready;

  // len of 0 stands for a full 2^DW-beat packet
  assign len_eff = (len == '0) ? {1'b1, {DW{1'b0}}}
                               : {1'b0, len};

  // a new packet uses the live len; a packet in flight uses the latched one
  assign cur_len  = (state_q == IDLE) ? len_eff : len_q;
  assign tag_last = (bcnt_q == cur_len - (DW+1)'(1));

  // packet FSM: track the beat position of each accepted upstream beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      len_q   <= '0;
    end else if (acc) begin
      unique case (state_q)
        IDLE: begin
          len_q <= len_eff;
          if (tag_last) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
          end else begin
            state_q <= BODY;
            bcnt_q  <= (DW+1)'(1);
          end
        end
        BODY: begin
          if (tag_last) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
          end else begin
            bcnt_q  <= bcnt_q + (DW+1)'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          bcnt_q  <= '0;
        end
      endcase
    end
  end

  // skid buffer next state: main refills from skid first, then from input
  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    sk_vld_d    = sk_vld_q;
    sk_data_d   = sk_data_q;
    sk_last_d   = sk_last_q;
    if (!main_vld_q || oxfer) begin
      if (sk_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = sk_data_q;
        main_last_d = sk_last_q;
        sk_vld_d    = 1'b0;
      end else begin
        main_vld_d = acc;
        if (acc) begin
          main_data_d = s_tdata;
          main_last_d = tag_last;
        end
      end
    end else if (acc) begin
      sk_vld_d  = 1'b1;
      sk_data_d = s_tdata;
      sk_last_d = tag_last;
    end
    rdy_d = !sk_vld_d;
  end

  // skid buffer registers, ready held low through reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_last_q <= 1'b0;
      sk_vld_q    <= 1'b0;
      sk_data_q   <= '0;
      sk_last_q   <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_last_q <= main_last_d;
      sk_vld_q    <= sk_vld_d;
      sk_data_q   <= sk_data_d;
      sk_last_q   <= sk_last_d;
      rdy_q       <= rdy_d;
    end
  end

  assign s_tready = rdy_q;
  assign m_tvalid = main_vld_q;
  assign m_tdata  = main_data_q;
  assign m_tlast  = main_last_q;

`ifdef AXIS_FRAMER_STATS_EN
  logic [CW-1:0] pkt_cnt_q;

  // count packets leaving the block, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else if (oxfer && main_last_q) begin
      pkt_cnt_q <= pkt_cnt_q + CW'(1);
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  // CW only sizes pkt_cnt; nothing to build here
  if (CW < 1) begin : g_no_cw
  end
`endif

endmodule

// File: tb/tb_axis_framer.sv
// Directed bench for axis_framer: cycle table plus scoreboarded streams.
// Define AXIS_FRAMER_STATS_EN to also check pkt_cnt.
module tb_axis_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;
  logic [7:0] len;
`ifdef AXIS_FRAMER_STATS_EN
  logic [15:0] pkt_cnt;
`endif

  int nchk = 0;
  int nerr = 0;

  axis_framer #(.DW(8), .CW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .len      (len)
`ifdef AXIS_FRAMER_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       mv;
    logic [7:0] md;
    logic       ml;
    logic       sr;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic v, input logic [7:0] d,
                              input logic r, input logic mv,
                              input logic [7:0] md, input logic ml,
                              input logic sr);
    vec_t t;
    t.v = v; t.d = d; t.r = r;
    t.mv = mv; t.md = md; t.ml = ml; t.sr = sr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_pkt(input string nm, input int exp);
`ifdef AXIS_FRAMER_STATS_EN
    chk(nm, 32'(pkt_cnt), 32'(exp));
`else
    if (exp < 0) $display("bad expected count for %s", nm);
`endif
  endtask

  // mode 0: ready=1, 1: toggle 1,0,..., 2: ready=0 for 5 cycles then 1
  task automatic run_stream(input string nm, input int n,
                            input logic [7:0] l1, input logic [7:0] l2,
                            input int chg, input int mode,
                            input int exp_tl, input int exp_cyc);
    logic [7:0] qd[$];
    logic       ql[$];
    logic [7:0] ed;
    logic       el;
    int sent = 0, got = 0, bad = 0, tl = 0, cyc = 0;
    int run = 0, maxrun = 0, pos = 0, lcur = 1;
    len = l1;
    while (got < n && cyc < 4 * n + 50) begin
      @(negedge clk);
      if (chg >= 0 && sent == chg) len = l2;
      if (mode == 0) m_tready = 1'b1;
      else if (mode == 1) m_tready = (cyc % 2 == 0);
      else m_tready = (cyc >= 5);
      s_tvalid = (sent < n);
      s_tdata  = 8'(sent + 1);
      #1;
      if (mode == 2 && cyc == 5) begin
        chk({nm, " buffered"}, 32'(sent), 32'd2);
        chk({nm, " s_tready stalled"}, 32'(s_tready), 32'd0);
      end
      if (s_tready) run = 0;
      else begin
        run++;
        if (run > maxrun) maxrun = run;
      end
      if (s_tvalid && s_tready) begin
        if (pos == 0) lcur = (len == 8'd0) ? 256 : int'(len);
        qd.push_back(s_tdata);
        ql.push_back(pos == lcur - 1);
        pos = (pos == lcur - 1) ? 0 : pos + 1;
        sent++;
      end
      if (m_tvalid && m_tready) begin
        if (qd.size() == 0) bad++;
        else begin
          ed = qd.pop_front();
          el = ql.pop_front();
          if (ed !== m_tdata || el !== m_tlast) bad++;
        end
        if (m_tlast) tl++;
        got++;
      end
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    chk({nm, " beats out"}, 32'(got), 32'(n));
    chk({nm, " bad beats"}, 32'(bad), 32'd0);
    chk({nm, " tlast count"}, 32'(tl), 32'(exp_tl));
    if (mode == 1) chk({nm, " max stall"}, 32'(maxrun), 32'd1);
    if (exp_cyc > 0) chk({nm, " cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    // len=4 cycle table: post-edge expected outputs
    tbl[0]  = mk(1'b1, 8'd1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1);
    tbl[1]  = mk(1'b1, 8'd2, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1);
    tbl[2]  = mk(1'b1, 8'd3, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 8'd4, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 8'd4, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 8'd4, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1);
    tbl[6]  = mk(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    tbl[7]  = mk(1'b1, 8'd5, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 8'd6, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 8'd0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 8'd7, 1'b1, 1'b1, 8'd7, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 8'd8, 1'b1, 1'b1, 8'd8, 1'b1, 1'b1);
    tbl[12] = mk(1'b0, 8'd0, 1'b0, 1'b1, 8'd8, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

    rst = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = 8'd0;
    m_tready = 1'b1;
    len = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {20'd0, m_tvalid, m_tlast, m_tdata, s_tready},
        32'd0);
    chk_pkt("reset pkt_cnt", 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("s_tready after reset", 32'(s_tready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      s_tvalid = tbl[i].v;
      s_tdata  = tbl[i].d;
      m_tready = tbl[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].mv));
      chk($sformatf("tbl%0d s_tready", i), 32'(s_tready), 32'(tbl[i].sr));
      if (tbl[i].mv) begin
        chk($sformatf("tbl%0d m_tdata", i), 32'(m_tdata), 32'(tbl[i].md));
        chk($sformatf("tbl%0d m_tlast", i), 32'(m_tlast), 32'(tbl[i].ml));
      end
    end
    chk_pkt("table pkt_cnt", 2);

    run_stream("len4x12", 12, 8'd4, 8'd4, -1, 0, 3, 13);
    chk_pkt("len4 pkt_cnt", 5);
    run_stream("len64 toggle", 256, 8'd64, 8'd64, -1, 1, 4, 0);
    run_stream("len0x512", 512, 8'd0, 8'd0, -1, 0, 2, 513);
    run_stream("len1", 5, 8'd1, 8'd1, -1, 0, 5, 6);
    run_stream("len 8to3", 17, 8'd8, 8'd3, 2, 0, 4, 18);
    run_stream("stall drain", 6, 8'd3, 8'd3, -1, 2, 2, 0);
    chk_pkt("stream pkt_cnt", 22);

    len = 8'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 8'(50 + i);
      m_tready = 1'b1;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid reset outputs", {20'd0, m_tvalid, m_tlast, m_tdata, s_tready},
        32'd0);
    chk_pkt("mid reset pkt_cnt", 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("s_tready after mid reset", 32'(s_tready), 32'd1);
    run_stream("post reset len8", 8, 8'd8, 8'd8, -1, 0, 1, 9);
    @(negedge clk);
    chk_pkt("post reset pkt_cnt", 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
